// File: rtl/shift_link_pkg.sv
// Shared definitions for the serial link: FSM encodings, default word size and parity sense.
// The receiver's optional parity stage is enabled with the PARITY_CHECK_EN macro.
package shift_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } linkState_t;

  localparam int   DEFAULT_BIT_LENGTH = 8;
  // 1'b0 selects even parity: the word plus its parity bit carry an even number of ones.
  localparam logic PARITY_ODD_SENSE   = 1'b0;

  function automatic logic parityFlag(input logic wordXor, input logic parityBit);
    return wordXor ^ parityBit ^ PARITY_ODD_SENSE;
  endfunction

endpackage

// File: rtl/rx_word_buf.sv
// One-entry valid/ready holding register for received words, with sticky overrun on a dropped word.
module rx_word_buf
  import shift_link_pkg::*;
#(
  parameter int dataWidth = DEFAULT_BIT_LENGTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [dataWidth-1:0] loadData,
  input  logic                 loadPar,
  input  logic                 dataReady,
  input  logic                 clrErr,
  output logic [dataWidth-1:0] dataBus,
  output logic                 dataValid,
  output logic                 overrun,
  output logic                 parityError
);

  logic [dataWidth-1:0] dataBus_r;
  logic                 dataValid_r;
  logic                 overrun_r;
  logic                 parityError_r;
  logic                 canAccept_s;
  logic                 drop_s;

  // The slot is free when empty or when its word leaves in this same cycle.
  always_comb begin
    canAccept_s = 1'b0;
    drop_s      = 1'b0;
    if (!dataValid_r || dataReady) begin
      canAccept_s = 1'b1;
    end else begin
      canAccept_s = 1'b0;
    end
    if (load && !canAccept_s) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
  end

  // Holding register: load a completed word when free, otherwise drain on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataBus_r     <= {dataWidth{1'b0}};
      parityError_r <= 1'b0;
      dataValid_r   <= 1'b0;
    end else if (load && canAccept_s) begin
      dataBus_r     <= loadData;
      parityError_r <= loadPar;
      dataValid_r   <= 1'b1;
    end else if (dataValid_r && dataReady) begin
      dataValid_r   <= 1'b0;
    end else begin
      dataValid_r   <= dataValid_r;
    end
  end

  // Sticky overrun; a fresh drop wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else if (clrErr) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign dataBus     = dataBus_r;
  assign dataValid   = dataValid_r;
  assign overrun     = overrun_r;
  assign parityError = parityError_r;

endmodule

// File: rtl/shift_in_reg.sv
// MSB-first serial-to-parallel receiver feeding a one-entry valid/ready buffer.
// Define PARITY_CHECK_EN to append an even-parity bit to every frame.
module shift_in_reg
  import shift_link_pkg::*;
#(
  parameter int bitLength = DEFAULT_BIT_LENGTH
) (
  input  logic                 shiftClk,
  input  logic                 reset,
  input  logic                 frameStart,
  input  logic                 shiftEnabled,
  input  logic                 serialIn,
  input  logic                 dataReady,
  input  logic                 clrErr,
  output logic [bitLength-1:0] dataBus,
  output logic                 dataValid,
  output logic                 shiftBusy,
  output logic                 overrun,
  output logic                 parityError
);

  localparam int             CNT_W    = $clog2(bitLength);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(bitLength - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  linkState_t           state_r;
  logic [bitLength-1:0] shiftReg_r;
  logic [CNT_W-1:0]     bitCnt_r;
  logic                 shiftBusy_r;
  logic                 wordDone_s;
  logic [bitLength-1:0] wordData_s;
  logic                 wordPar_s;

  // Word completion is decoded from the current strobe so the buffer loads on that same edge.
  always_comb begin
    wordDone_s = 1'b0;
    wordData_s = {shiftReg_r[bitLength-2:0], serialIn};
    wordPar_s  = 1'b0;
    if (shiftEnabled && !frameStart) begin
      case (state_r)
        SHIFT: begin
`ifdef PARITY_CHECK_EN
          wordDone_s = 1'b0;
`else
          if (bitCnt_r == ONE_CNT) begin
            wordDone_s = 1'b1;
          end else begin
            wordDone_s = 1'b0;
          end
`endif
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          wordDone_s = 1'b1;
          wordData_s = shiftReg_r;
          wordPar_s  = parityFlag(^shiftReg_r, serialIn);
        end
`endif
        default: wordDone_s = 1'b0;
      endcase
    end else begin
      wordDone_s = 1'b0;
    end
  end

  // Frame FSM, shift register and bit counter; a start strobe always restarts the frame.
  always_ff @(posedge shiftClk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      shiftReg_r  <= {bitLength{1'b0}};
      bitCnt_r    <= {CNT_W{1'b0}};
      shiftBusy_r <= 1'b0;
    end else if (shiftEnabled) begin
      if (frameStart) begin
        state_r     <= SHIFT;
        shiftReg_r  <= {{(bitLength-1){1'b0}}, serialIn};
        bitCnt_r    <= LAST_CNT;
        shiftBusy_r <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            state_r     <= IDLE;
            shiftBusy_r <= 1'b0;
          end
          SHIFT: begin
            shiftReg_r <= {shiftReg_r[bitLength-2:0], serialIn};
            bitCnt_r   <= bitCnt_r - ONE_CNT;
            if (bitCnt_r == ONE_CNT) begin
`ifdef PARITY_CHECK_EN
              state_r     <= PARITY;
              shiftBusy_r <= 1'b1;
`else
              state_r     <= IDLE;
              shiftBusy_r <= 1'b0;
`endif
            end else begin
              state_r     <= SHIFT;
              shiftBusy_r <= 1'b1;
            end
          end
`ifdef PARITY_CHECK_EN
          PARITY: begin
            state_r     <= IDLE;
            shiftBusy_r <= 1'b0;
          end
`endif
          default: begin
            state_r     <= IDLE;
            bitCnt_r    <= {CNT_W{1'b0}};
            shiftBusy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  rx_word_buf #(
    .dataWidth (bitLength)
  ) wordBuf (
    .clk         (shiftClk),
    .reset       (reset),
    .load        (wordDone_s),
    .loadData    (wordData_s),
    .loadPar     (wordPar_s),
    .dataReady   (dataReady),
    .clrErr      (clrErr),
    .dataBus     (dataBus),
    .dataValid   (dataValid),
    .overrun     (overrun),
    .parityError (parityError)
  );

  assign shiftBusy = shiftBusy_r;

endmodule

// File: tb/tb_shift_in_reg.sv
// Bench for shift_in_reg: queue-based frame model checked every cycle, plus directed literal checks.
module tb_shift_in_reg;

  localparam int BL = 8;
`ifdef PARITY_CHECK_EN
  localparam int FRAME_LEN = BL + 1;
`else
  localparam int FRAME_LEN = BL;
`endif

  logic          shiftClk = 1'b0;
  logic          reset = 1'b1;
  logic          frameStart = 1'b0;
  logic          shiftEnabled = 1'b0;
  logic          serialIn = 1'b0;
  logic          dataReady = 1'b1;
  logic          clrErr = 1'b0;
  logic [BL-1:0] dataBus;
  logic          dataValid;
  logic          shiftBusy;
  logic          overrun;
  logic          parityError;

  int errors = 0;
  int checks = 0;
  bit chkEn = 1'b0;

  shift_in_reg #(.bitLength(BL)) dut (
    .shiftClk     (shiftClk),
    .reset        (reset),
    .frameStart   (frameStart),
    .shiftEnabled (shiftEnabled),
    .serialIn     (serialIn),
    .dataReady    (dataReady),
    .clrErr       (clrErr),
    .dataBus      (dataBus),
    .dataValid    (dataValid),
    .shiftBusy    (shiftBusy),
    .overrun      (overrun),
    .parityError  (parityError)
  );

  always #5 shiftClk = ~shiftClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: collected bits of the current frame and the expected buffer contents.
  bit            q[$];
  bit            inFrame;
  bit [BL-1:0]   mBus;
  bit            mValid;
  bit            mOver;
  bit            mPar;
  bit            done;
  bit            oldValid;
  bit [BL-1:0]   w;
  bit            p;

  always @(posedge shiftClk or posedge reset) begin
    if (reset) begin
      q.delete();
      inFrame = 1'b0;
      mBus = '0;
      mValid = 1'b0;
      mOver = 1'b0;
      mPar = 1'b0;
    end else begin
      done = 1'b0;
      oldValid = mValid;
      if (shiftEnabled) begin
        if (frameStart) begin
          q.delete();
          q.push_back(serialIn);
          inFrame = 1'b1;
        end else if (inFrame) begin
          q.push_back(serialIn);
        end
      end
      if (inFrame && q.size() == FRAME_LEN) begin
        w = '0;
        for (int i = 0; i < BL; i++) w = (w << 1) | BL'(q[i]);
        p = 1'b0;
`ifdef PARITY_CHECK_EN
        p = (^w) ^ q[BL];
`endif
        done = 1'b1;
        inFrame = 1'b0;
        q.delete();
      end
      if (done && (!oldValid || dataReady)) begin
        mBus = w;
        mPar = p;
        mValid = 1'b1;
      end else if (oldValid && dataReady) begin
        mValid = 1'b0;
      end
      if (done && oldValid && !dataReady) mOver = 1'b1;
      else if (clrErr) mOver = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge shiftClk) begin
    if (chkEn) begin
      check("dataValid", 32'(dataValid), 32'(mValid));
      check("dataBus", 32'(dataBus), 32'(mBus));
      check("overrun", 32'(overrun), 32'(mOver));
      check("shiftBusy", 32'(shiftBusy), 32'(inFrame));
      check("parityError", 32'(parityError), 32'(mPar));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge shiftClk);
  endtask

  task automatic strobe(input bit fs, input bit b);
    @(posedge shiftClk);
    #1;
    shiftEnabled = 1'b1;
    frameStart = fs;
    serialIn = b;
    @(posedge shiftClk);
    #1;
    shiftEnabled = 1'b0;
    frameStart = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] word, input bit pb, input int gap);
    for (int i = BL - 1; i >= 0; i--) begin
      idle(gap);
      strobe(i == BL - 1, word[i]);
    end
`ifdef PARITY_CHECK_EN
    idle(gap);
    strobe(1'b0, pb);
`else
    if (pb) idle(0);
`endif
  endtask

  initial begin
    @(posedge shiftClk);
    #1;
    chkEn = 1'b1;
    @(posedge shiftClk);
    #1;
    check("rst_valid", 32'(dataValid), 32'd0);
    check("rst_bus", 32'(dataBus), 32'd0);
    check("rst_busy", 32'(shiftBusy), 32'd0);
    reset = 1'b0;
    idle(2);

    // Single frame, strobe every 3 clocks.
    sendFrame(8'hA5, 1'b0, 1);
    check("a5_valid", 32'(dataValid), 32'd1);
    check("a5_bus", 32'(dataBus), 32'hA5);
    @(posedge shiftClk);
    #1;
    check("a5_valid_drop", 32'(dataValid), 32'd0);

    // Back-to-back with consumer stalled.
    dataReady = 1'b0;
    sendFrame(8'h01, 1'b1, 0);
    sendFrame(8'h80, 1'b1, 0);
    check("ovr_bus", 32'(dataBus), 32'h01);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_valid", 32'(dataValid), 32'd1);
    @(posedge shiftClk);
    #1;
    clrErr = 1'b1;
    @(posedge shiftClk);
    #1;
    clrErr = 1'b0;
    check("ovr_clear", 32'(overrun), 32'd0);
    dataReady = 1'b1;
    idle(2);

    // Restart after 5 bits, then a full 0xFF.
    strobe(1'b1, 1'b1);
    strobe(1'b0, 1'b0);
    strobe(1'b0, 1'b1);
    strobe(1'b0, 1'b0);
    strobe(1'b0, 1'b0);
    sendFrame(8'hFF, 1'b0, 0);
    check("restart_bus", 32'(dataBus), 32'hFF);
    check("restart_valid", 32'(dataValid), 32'd1);
    check("restart_ovr", 32'(overrun), 32'd0);
    idle(2);

    // Idle-line strobes without frameStart.
    for (int i = 0; i < 10; i++) begin
      strobe(1'b0, i[0]);
      check("idle_valid", 32'(dataValid), 32'd0);
      check("idle_busy", 32'(shiftBusy), 32'd0);
    end

    // Reset mid-frame with a held word.
    dataReady = 1'b0;
    sendFrame(8'h5A, 1'b0, 0);
    strobe(1'b1, 1'b1);
    strobe(1'b0, 1'b0);
    strobe(1'b0, 1'b1);
    strobe(1'b0, 1'b0);
    check("mid_busy", 32'(shiftBusy), 32'd1);
    check("mid_held", 32'(dataBus), 32'h5A);
    reset = 1'b1;
    #2;
    check("arst_bus", 32'(dataBus), 32'd0);
    check("arst_valid", 32'(dataValid), 32'd0);
    check("arst_busy", 32'(shiftBusy), 32'd0);
    @(posedge shiftClk);
    #1;
    reset = 1'b0;
    dataReady = 1'b1;
    sendFrame(8'h3C, 1'b0, 0);
    check("post_rst_bus", 32'(dataBus), 32'h3C);
    check("post_rst_valid", 32'(dataValid), 32'd1);
    idle(2);

`ifdef PARITY_CHECK_EN
    sendFrame(8'h07, 1'b1, 0);
    check("par_ok_bus", 32'(dataBus), 32'h07);
    check("par_ok_flag", 32'(parityError), 32'd0);
    idle(2);
    sendFrame(8'h07, 1'b0, 0);
    check("par_bad_bus", 32'(dataBus), 32'h07);
    check("par_bad_flag", 32'(parityError), 32'd1);
    idle(2);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(posedge shiftClk);
      #1;
      reset = ($urandom_range(0, 599) == 0);
      shiftEnabled = ($urandom_range(0, 2) == 0);
      frameStart = shiftEnabled ? ($urandom_range(0, 11) == 0) : 1'($urandom_range(0, 1));
      serialIn = 1'($urandom_range(0, 1));
      dataReady = ($urandom_range(0, 3) != 0);
      clrErr = ($urandom_range(0, 31) == 0);
    end
    @(posedge shiftClk);
    #1;
    reset = 1'b0;
    shiftEnabled = 1'b0;
    frameStart = 1'b0;
    clrErr = 1'b0;
    idle(3);
    chkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
